// File: rtl/scandoubler_pkg.sv
// Shared constants and types for the scandoubler video-capture write path.
// Burst geometry, read-side state encoding and the burst tag layout.
package scandoubler_pkg;

   localparam int BURST_WORDS = 8;
   localparam int COL_W_DEF   = 11;
   localparam int ROW_W_DEF   = 11;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_REQ  = 2'd1,
      RD_GAP  = 2'd2
   } rd_state_t;

   typedef struct packed {
      logic [1:0]           frame;
      logic [ROW_W_DEF-1:0] row;
      logic [COL_W_DEF-1:0] col;
   } burst_tag_t;

endpackage

// File: rtl/scandoubler_burst_buf.sv
// Two-bank ping-pong burst store: per-bank word data, valid mask, full flag and tag.
// Words never written since the bank was last emptied read back as 0x0000 (line padding).
module scandoubler_burst_buf
   import scandoubler_pkg::*;
#(
   parameter int WORDS = 8,
   parameter int TAG_W = 24
) (
   input  logic                     clk_96,
   input  logic                     reset,
   input  logic                     i_wr_en,
   input  logic                     i_wr_bank,
   input  logic [$clog2(WORDS)-1:0] i_wr_ptr,
   input  logic [15:0]              i_wr_data,
   input  logic                     i_mark_full,
   input  logic                     i_full_bank,
   input  logic [TAG_W-1:0]         i_full_tag,
   input  logic                     i_rd_bank,
   input  logic [$clog2(WORDS)-1:0] i_rd_ptr,
   input  logic                     i_mark_empty,
   output logic [15:0]              o_rd_data,
   output logic [TAG_W-1:0]         o_rd_tag,
   output logic [1:0]               o_full
);

   logic [15:0]      r_mem   [2][WORDS];
   logic [WORDS-1:0] r_valid [2];
   logic [TAG_W-1:0] r_tag   [2];
   logic [1:0]       r_full;

   always_ff @(posedge clk_96) begin
      if (i_wr_en) r_mem[i_wr_bank][i_wr_ptr] <= i_wr_data;
   end

   // Write/empty and full/empty never hit the same bank in one cycle, so the
   // per-bank updates below are independent.
   always_ff @(posedge clk_96) begin
      if (reset) begin
         r_valid[0] <= '0;
         r_valid[1] <= '0;
         r_tag[0]   <= '0;
         r_tag[1]   <= '0;
         r_full     <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (i_wr_en && (i_wr_bank == 1'(b))) r_valid[b][i_wr_ptr] <= 1'b1;
            if (i_mark_empty && (i_rd_bank == 1'(b))) begin
               r_valid[b] <= '0;
               r_full[b]  <= 1'b0;
            end
            if (i_mark_full && (i_full_bank == 1'(b))) begin
               r_full[b] <= 1'b1;
               r_tag[b]  <= i_full_tag;
            end
         end
      end
   end

   assign o_rd_data = r_valid[i_rd_bank][i_rd_ptr] ? r_mem[i_rd_bank][i_rd_ptr] : 16'h0000;
   assign o_rd_tag  = r_tag[i_rd_bank];
   assign o_full    = r_full;

endmodule

// File: rtl/scandoubler_vidin_writer.sv
// Packs the pixel-word stream into 8-word tagged bursts and streams them to the
// SDRAM controller's vidin port.
module scandoubler_vidin_writer
   import scandoubler_pkg::*;
#(
   parameter int BURST_WORDS = scandoubler_pkg::BURST_WORDS,
   parameter int COL_W       = scandoubler_pkg::COL_W_DEF,
   parameter int ROW_W       = scandoubler_pkg::ROW_W_DEF
) (
   input  logic             clk_96,
   input  logic             reset,
   input  logic             pix_ce,
   input  logic [15:0]      pix_d,
   input  logic             line_start,
   input  logic             frame_start,
   output logic             vidin_req,
   output logic [1:0]       vidin_frame,
   output logic [ROW_W-1:0] vidin_row,
   output logic [COL_W-1:0] vidin_col,
   output logic [15:0]      vidin_d,
   input  logic             vidin_ack,
   output logic             overflow,
   output rd_state_t        dbg_rd_state
);

   localparam int PTR_W = $clog2(BURST_WORDS);
   localparam int TAG_W = 2 + ROW_W + COL_W;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BURST_WORDS - 1);

   logic             r_wr_bank;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [1:0]       r_frame;
   logic             r_overflow;

   logic             w_brk, w_pad, w_bank, w_accept, w_drop, w_last;
   logic [PTR_W-1:0] w_ptr;
   logic [COL_W-1:0] w_col;
   logic [ROW_W-1:0] w_row;
   logic [1:0]       w_frame;
   logic             w_mark_full, w_full_bank;
   logic [TAG_W-1:0] w_full_tag;
   logic [1:0]       w_full;
   logic [15:0]      w_rd_data;
   logic [TAG_W-1:0] w_rd_tag;

   // Line/frame break is applied before the same-cycle pixel: the w_* values
   // describe the write position after any padding of the partial bank.
   assign w_brk       = line_start | frame_start;
   assign w_pad       = w_brk && (r_wr_ptr != '0);
   assign w_bank      = w_pad ? ~r_wr_bank : r_wr_bank;
   assign w_ptr       = w_pad ? '0 : r_wr_ptr;
   assign w_row       = frame_start ? '0 : (line_start ? r_row + ROW_W'(1) : r_row);
   assign w_col       = w_brk ? '0 : r_col;
   assign w_frame     = frame_start ? r_frame + 2'd1 : r_frame;
   assign w_accept    = pix_ce && !w_full[w_bank];
   assign w_drop      = pix_ce && w_full[w_bank];
   assign w_last      = w_accept && (w_ptr == LAST_PTR);
   assign w_mark_full = w_pad | w_last;
   assign w_full_bank = w_pad ? r_wr_bank : w_bank;
   assign w_full_tag  = w_pad ? {r_frame, r_row, r_col} : {w_frame, w_row, w_col};

   always_ff @(posedge clk_96) begin
      if (reset) begin
         r_wr_bank  <= 1'b0;
         r_wr_ptr   <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_frame    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_bank <= w_last ? ~w_bank : w_bank;
         r_wr_ptr  <= w_last ? '0 : (w_accept ? w_ptr + PTR_W'(1) : w_ptr);
         r_col     <= w_last ? w_col + COL_W'(BURST_WORDS) : w_col;
         r_row     <= w_row;
         r_frame   <= w_frame;
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Read side. Handshake: vidin_req is a valid that stays high for the whole
   // burst; each cycle with vidin_ack high consumes one word, and that word
   // appears on vidin_d in the following cycle. Req drops after the 8th ack.
   rd_state_t        r_rd_state, w_state_nxt;
   logic             r_rd_bank, w_rd_bank_nxt;
   logic [PTR_W-1:0] r_rd_cnt, w_rd_cnt_nxt;
   logic             r_req, w_req_nxt;
   logic [TAG_W-1:0] r_tag, w_tag_nxt;
   logic [15:0]      r_d, w_d_nxt;
   logic             w_mark_empty;

   always_comb begin
      w_state_nxt   = r_rd_state;
      w_rd_bank_nxt = r_rd_bank;
      w_rd_cnt_nxt  = r_rd_cnt;
      w_req_nxt     = r_req;
      w_tag_nxt     = r_tag;
      w_d_nxt       = r_d;
      w_mark_empty  = 1'b0;
      case (r_rd_state)
         RD_IDLE: begin
            if (w_full[r_rd_bank]) begin
               w_tag_nxt    = w_rd_tag;
               w_rd_cnt_nxt = '0;
               w_req_nxt    = 1'b1;
               w_state_nxt  = RD_REQ;
            end
         end
         RD_REQ: begin
            if (vidin_ack) begin
               w_d_nxt      = w_rd_data;
               w_rd_cnt_nxt = r_rd_cnt + PTR_W'(1);
               if (r_rd_cnt == LAST_PTR) begin
                  w_req_nxt     = 1'b0;
                  w_mark_empty  = 1'b1;
                  w_rd_bank_nxt = ~r_rd_bank;
                  w_state_nxt   = RD_GAP;
               end
            end
         end
         RD_GAP:  w_state_nxt = RD_IDLE;
         default: begin
            w_state_nxt = RD_IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_96) begin
      if (reset) begin
         r_rd_state <= RD_IDLE;
         r_rd_bank  <= 1'b0;
         r_rd_cnt   <= '0;
         r_req      <= 1'b0;
         r_tag      <= '0;
         r_d        <= '0;
      end else begin
         r_rd_state <= w_state_nxt;
         r_rd_bank  <= w_rd_bank_nxt;
         r_rd_cnt   <= w_rd_cnt_nxt;
         r_req      <= w_req_nxt;
         r_tag      <= w_tag_nxt;
         r_d        <= w_d_nxt;
      end
   end

   scandoubler_burst_buf #(
      .WORDS (BURST_WORDS),
      .TAG_W (TAG_W)
   ) u_buf (
      .clk_96       (clk_96),
      .reset        (reset),
      .i_wr_en      (w_accept),
      .i_wr_bank    (w_bank),
      .i_wr_ptr     (w_ptr),
      .i_wr_data    (pix_d),
      .i_mark_full  (w_mark_full),
      .i_full_bank  (w_full_bank),
      .i_full_tag   (w_full_tag),
      .i_rd_bank    (r_rd_bank),
      .i_rd_ptr     (r_rd_cnt),
      .i_mark_empty (w_mark_empty),
      .o_rd_data    (w_rd_data),
      .o_rd_tag     (w_rd_tag),
      .o_full       (w_full)
   );

   assign vidin_req                          = r_req;
   assign {vidin_frame, vidin_row, vidin_col} = r_tag;
   assign vidin_d                            = r_d;
   assign overflow                           = r_overflow;
   assign dbg_rd_state                       = r_rd_state;

endmodule

// File: tb/tb_scandoubler_vidin_writer.sv
// Directed bench for scandoubler_vidin_writer: burst table plus hand-written
// overflow, gapped-ack, mid-burst reset and same-cycle line_start sequences.
module tb_scandoubler_vidin_writer;
   import scandoubler_pkg::*;

   logic        clk_96 = 1'b0;
   logic        reset;
   logic        pix_ce;
   logic [15:0] pix_d;
   logic        line_start;
   logic        frame_start;
   logic        vidin_req;
   logic [1:0]  vidin_frame;
   logic [10:0] vidin_row;
   logic [10:0] vidin_col;
   logic [15:0] vidin_d;
   logic        vidin_ack;
   logic        overflow;
   rd_state_t   dbg_rd_state;

   int n_chk  = 0;
   int n_fail = 0;
   logic [15:0] exp_q[$];

   always #5 clk_96 = ~clk_96;

   scandoubler_vidin_writer dut (
      .clk_96       (clk_96),
      .reset        (reset),
      .pix_ce       (pix_ce),
      .pix_d        (pix_d),
      .line_start   (line_start),
      .frame_start  (frame_start),
      .vidin_req    (vidin_req),
      .vidin_frame  (vidin_frame),
      .vidin_row    (vidin_row),
      .vidin_col    (vidin_col),
      .vidin_d      (vidin_d),
      .vidin_ack    (vidin_ack),
      .overflow     (overflow),
      .dbg_rd_state (dbg_rd_state)
   );

   typedef struct {
      int          n_pix;
      logic [15:0] base;
      logic [1:0]  brk;      // 0 none, 1 line_start, 2 frame_start (after the pixels)
      burst_tag_t  exp_tag;
      int          exp_valid;
   } vec_t;

   vec_t vecs[9];

   function automatic burst_tag_t mk_tag(input int f, input int r, input int c);
      burst_tag_t t;
      t.frame = 2'(f);
      t.row   = 11'(r);
      t.col   = 11'(c);
      return t;
   endfunction

   task automatic tick();
      @(posedge clk_96);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_words(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         pix_ce = 1'b1;
         pix_d  = base + 16'(i);
         tick();
      end
      pix_ce = 1'b0;
   endtask

   task automatic pulse_brk(input logic [1:0] kind);
      if (kind != 2'd0) begin
         line_start  = (kind == 2'd1);
         frame_start = (kind == 2'd2);
         tick();
         line_start  = 1'b0;
         frame_start = 1'b0;
      end
   endtask

   task automatic push_burst(input logic [15:0] base, input int n_valid);
      for (int i = 0; i < 8; i++) exp_q.push_back((i < n_valid) ? base + 16'(i) : 16'h0000);
   endtask

   task automatic wait_req(input string name);
      int c;
      c = 0;
      while (!vidin_req && c < 64) begin
         tick();
         c++;
      end
      chk({name, "_req_rise"}, 32'(vidin_req), 32'd1);
   endtask

   task automatic pop_exp(output logic [15:0] w);
      if (exp_q.size() == 0) begin
         w = 16'hxxxx;
         n_chk++;
         n_fail++;
         $display("FAIL exp_q_empty actual=0 required=1");
      end else begin
         w = exp_q.pop_front();
      end
   endtask

   task automatic drain(input burst_tag_t t, input string name);
      logic [15:0] w;
      wait_req(name);
      chk({name, "_tag"}, 32'({vidin_frame, vidin_row, vidin_col}), 32'(t));
      chk({name, "_state"}, 32'(dbg_rd_state), 32'(RD_REQ));
      for (int i = 0; i < 8; i++) begin
         vidin_ack = 1'b1;
         tick();
         pop_exp(w);
         chk($sformatf("%s_d%0d", name, i), 32'(vidin_d), 32'(w));
         chk($sformatf("%s_req%0d", name, i), 32'(vidin_req), (i < 7) ? 32'd1 : 32'd0);
      end
      vidin_ack = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] w;

      vecs[0] = '{8, 16'h0001, 2'd0, mk_tag(0, 0, 0), 8};
      vecs[1] = '{3, 16'h0009, 2'd1, mk_tag(0, 0, 8), 3};
      vecs[2] = '{8, 16'h0101, 2'd0, mk_tag(0, 1, 0), 8};
      vecs[3] = '{8, 16'h0201, 2'd2, mk_tag(0, 1, 8), 8};
      vecs[4] = '{8, 16'h0301, 2'd2, mk_tag(1, 0, 0), 8};
      vecs[5] = '{8, 16'h0401, 2'd2, mk_tag(2, 0, 0), 8};
      vecs[6] = '{8, 16'h0501, 2'd2, mk_tag(3, 0, 0), 8};
      vecs[7] = '{8, 16'h0601, 2'd0, mk_tag(0, 0, 0), 8};
      vecs[8] = '{5, 16'h0701, 2'd2, mk_tag(0, 0, 8), 5};

      reset = 1'b1; pix_ce = 1'b0; pix_d = '0;
      line_start = 1'b0; frame_start = 1'b0; vidin_ack = 1'b0;
      repeat (3) tick();
      chk("rst_req", 32'(vidin_req), 32'd0);
      chk("rst_tag", 32'({vidin_frame, vidin_row, vidin_col}), 32'd0);
      chk("rst_d", 32'(vidin_d), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_state", 32'(dbg_rd_state), 32'(RD_IDLE));
      reset = 1'b0;
      tick();

      for (int k = 0; k < 9; k++) begin
         push_burst(vecs[k].base, vecs[k].exp_valid);
         send_words(vecs[k].n_pix, vecs[k].base);
         pulse_brk(vecs[k].brk);
         drain(vecs[k].exp_tag, $sformatf("v%0d", k));
      end

      // Overflow: no acks, 24 words, last 8 dropped
      push_burst(16'h1001, 8);
      push_burst(16'h1009, 8);
      send_words(16, 16'h1001);
      chk("ovf_before", 32'(overflow), 32'd0);
      send_words(8, 16'h1011);
      chk("ovf_set", 32'(overflow), 32'd1);
      drain(mk_tag(1, 0, 0), "ovf_b0");
      drain(mk_tag(1, 0, 8), "ovf_b1");
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Ack while idle has no effect
      vidin_ack = 1'b1;
      repeat (3) tick();
      vidin_ack = 1'b0;
      chk("idle_ack_d", 32'(vidin_d), 32'h1010);
      chk("idle_ack_req", 32'(vidin_req), 32'd0);

      // Gapped acks
      push_burst(16'h2001, 8);
      send_words(8, 16'h2001);
      wait_req("gap");
      chk("gap_tag", 32'({vidin_frame, vidin_row, vidin_col}), 32'(mk_tag(1, 0, 16)));
      for (int i = 0; i < 8; i++) begin
         vidin_ack = 1'b1;
         tick();
         vidin_ack = 1'b0;
         pop_exp(w);
         chk($sformatf("gap_d%0d", i), 32'(vidin_d), 32'(w));
         repeat (2) tick();
         chk($sformatf("gap_hold%0d", i), 32'(vidin_d), 32'(w));
         chk($sformatf("gap_req%0d", i), 32'(vidin_req), (i < 7) ? 32'd1 : 32'd0);
      end

      // Reset in the middle of a burst
      push_burst(16'h3001, 8);
      send_words(8, 16'h3001);
      wait_req("mid");
      chk("mid_tag", 32'({vidin_frame, vidin_row, vidin_col}), 32'(mk_tag(1, 0, 24)));
      for (int i = 0; i < 4; i++) begin
         vidin_ack = 1'b1;
         tick();
         pop_exp(w);
         chk($sformatf("mid_d%0d", i), 32'(vidin_d), 32'(w));
      end
      vidin_ack = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      chk("mid_rst_req", 32'(vidin_req), 32'd0);
      chk("mid_rst_tag", 32'({vidin_frame, vidin_row, vidin_col}), 32'd0);
      chk("mid_rst_d", 32'(vidin_d), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      push_burst(16'h4001, 8);
      send_words(8, 16'h4001);
      drain(mk_tag(0, 0, 0), "post_rst");

      // line_start together with pix_ce: pixel becomes word 0 of the next row
      push_burst(16'h5001, 2);
      push_burst(16'h5003, 8);
      send_words(2, 16'h5001);
      line_start = 1'b1;
      pix_ce     = 1'b1;
      pix_d      = 16'h5003;
      tick();
      line_start = 1'b0;
      send_words(7, 16'h5004);
      drain(mk_tag(0, 0, 8), "same_pad");
      drain(mk_tag(0, 1, 0), "same_new");
      chk("same_ovf", 32'(overflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
